// File: rtl/fetch_mt.sv
// fetch_mt: multi-thread instruction fetch stage.
//
// Keeps one program counter per hardware thread and issues one enabled
// thread per cycle in round-robin order. The issued address goes to a
// synchronous instruction memory with one cycle of read latency. The word
// that comes back is returned one cycle later, tagged with its thread id.
//
// Ports:
//   clk         clock; all state updates on the rising edge
//   rst         asynchronous active-high reset
//   core_en     per-thread enable (bit t low makes thread t ineligible)
//   stall       global hold
//   branch_en   redirect request
//   branch_tid  thread to redirect
//   branch_val  redirect target
//   fetch_addr  memory read address (combinational)
//   fetch_data  memory read data for the previous cycle's address
//   ins         fetched instruction; all-zero when ins_valid is low
//   ins_tid     thread of ins
//   ins_valid   ins is a live instruction
module fetch_mt #(
  parameter int AW = 16,
  parameter int DW = 16,
  parameter int NT = 4,
  parameter logic [AW-1:0] RESET_PC = {AW{1'b0}},
  localparam int TW = (NT > 1) ? $clog2(NT) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [NT-1:0] core_en,
  input  logic          stall,
  input  logic          branch_en,
  input  logic [TW-1:0] branch_tid,
  input  logic [AW-1:0] branch_val,
  output logic [AW-1:0] fetch_addr,
  input  logic [DW-1:0] fetch_data,
  output logic [DW-1:0] ins,
  output logic [TW-1:0] ins_tid,
  output logic          ins_valid
);

  logic [AW-1:0] pc_q [NT];
  logic [AW-1:0] pc_d [NT];
  logic          iss_valid_q, iss_valid_d;
  logic [TW-1:0] iss_tid_q, iss_tid_d;
  logic [TW-1:0] last_tid_q, last_tid_d;
  logic [AW-1:0] hold_addr_q, hold_addr_d;

  logic [TW-1:0] sel_s;
  logic [TW-1:0] cand_s;
  logic          any_en_s;
  logic          issue_s;
  logic [AW-1:0] eff_sel_s;
  logic          squash_s;

  // Round-robin pick: first enabled thread after last_tid, wrapping back to
  // last_tid itself so a lone enabled thread issues every cycle.
  always_comb begin
    sel_s    = last_tid_q;
    cand_s   = last_tid_q;
    any_en_s = 1'b0;
    for (int k = 1; k <= NT; k++) begin
      cand_s = TW'((int'(last_tid_q) + k) % NT);
      if (!any_en_s && core_en[cand_s]) begin
        any_en_s = 1'b1;
        sel_s    = cand_s;
      end else begin
        any_en_s = any_en_s;
      end
    end
  end

  // Issue decision and effective PC of the selected thread; a branch on the
  // selected thread takes effect in the same cycle.
  always_comb begin
    issue_s  = ~stall & any_en_s;
    squash_s = branch_en & (branch_tid == iss_tid_q);
    if (branch_en && (branch_tid == sel_s)) begin
      eff_sel_s = branch_val;
    end else begin
      eff_sel_s = pc_q[sel_s];
    end
  end

  // Memory address: new issue, otherwise re-read the held in-flight address.
  always_comb begin
    if (rst) begin
      fetch_addr = RESET_PC;
    end else if (issue_s) begin
      fetch_addr = eff_sel_s;
    end else begin
      fetch_addr = hold_addr_q;
    end
  end

  // Next-state computation for PCs and the issue pipeline register.
  always_comb begin
    for (int t = 0; t < NT; t++) begin
      pc_d[t] = pc_q[t];
    end
    iss_valid_d = iss_valid_q;
    iss_tid_d   = iss_tid_q;
    last_tid_d  = last_tid_q;
    hold_addr_d = hold_addr_q;

    // A branch to a thread that is not issuing just retargets its PC; the
    // issuing thread's PC is overwritten below with the post-issue value.
    if (branch_en && (int'(branch_tid) < NT)) begin
      pc_d[branch_tid] = branch_val;
    end else begin
      pc_d[0] = pc_d[0];
    end

    if (stall) begin
      // Held instruction survives the stall unless squashed by a branch.
      iss_valid_d = iss_valid_q & ~squash_s;
    end else if (issue_s) begin
      pc_d[sel_s] = eff_sel_s + {{(AW-1){1'b0}}, 1'b1};
      iss_valid_d = 1'b1;
      iss_tid_d   = sel_s;
      last_tid_d  = sel_s;
      hold_addr_d = fetch_addr;
    end else begin
      iss_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int t = 0; t < NT; t++) begin
        pc_q[t] <= RESET_PC;
      end
      iss_valid_q <= 1'b0;
      iss_tid_q   <= {TW{1'b0}};
      last_tid_q  <= TW'(NT - 1);
      hold_addr_q <= RESET_PC;
    end else begin
      for (int t = 0; t < NT; t++) begin
        pc_q[t] <= pc_d[t];
      end
      iss_valid_q <= iss_valid_d;
      iss_tid_q   <= iss_tid_d;
      last_tid_q  <= last_tid_d;
      hold_addr_q <= hold_addr_d;
    end
  end

  // Delivery: the returning word is dropped on stall, on a disabled thread,
  // or when a branch redirects the thread it belongs to.
  always_comb begin
    ins_tid   = iss_tid_q;
    ins_valid = iss_valid_q & ~rst & ~stall & core_en[iss_tid_q] & ~squash_s;
    if (ins_valid) begin
      ins = fetch_data;
    end else begin
      ins = {DW{1'b0}};
    end
  end

endmodule

// File: tb/tb_fetch_mt.sv
// Directed testbench for fetch_mt (NT=4, AW=DW=16). The memory model
// returns the registered fetch address XOR 16'hA5A5.
module tb_fetch_mt;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  core_en;
  logic        stall;
  logic        branch_en;
  logic [1:0]  branch_tid;
  logic [15:0] branch_val;
  logic [15:0] fetch_addr;
  logic [15:0] fetch_data;
  logic [15:0] ins;
  logic [1:0]  ins_tid;
  logic        ins_valid;

  int errors = 0;
  int checks = 0;

  fetch_mt #(.AW(16), .DW(16), .NT(4), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .core_en(core_en), .stall(stall),
    .branch_en(branch_en), .branch_tid(branch_tid), .branch_val(branch_val),
    .fetch_addr(fetch_addr), .fetch_data(fetch_data),
    .ins(ins), .ins_tid(ins_tid), .ins_valid(ins_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) fetch_data <= fetch_addr ^ 16'hA5A5;

  task automatic cyc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst = 1'b1; stall = 1'b0; branch_en = 1'b0; branch_tid = 2'd0;
    branch_val = 16'h0000; core_en = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; stall = 1'b0; branch_en = 1'b0; branch_tid = 2'd0;
    branch_val = 16'h0000; core_en = 4'b1111;
    @(negedge clk);
    #1;
    checks++;
    if (fetch_addr !== 16'h0000 || ins_valid !== 1'b0 || ins !== 16'h0000 || ins_tid !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs: got addr=%h valid=%b ins=%h tid=%0d, want 0000/0/0000/0",
               fetch_addr, ins_valid, ins, ins_tid);
    end
    cyc();
  endtask

  task automatic test_single_thread;
    logic [15:0] exp_ins [4];
    logic        exp_v   [4];
    exp_ins[0] = 16'h0000; exp_ins[1] = 16'hA5A5; exp_ins[2] = 16'hA5A4; exp_ins[3] = 16'hA5A7;
    exp_v[0] = 1'b0; exp_v[1] = 1'b1; exp_v[2] = 1'b1; exp_v[3] = 1'b1;
    do_reset();
    core_en = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (fetch_addr !== 16'(i) || ins_valid !== exp_v[i] || ins !== exp_ins[i] || ins_tid !== 2'd0) begin
        errors++;
        $display("FAIL single_cycle%0d: got addr=%h valid=%b ins=%h tid=%0d, want %h/%b/%h/0",
                 i, fetch_addr, ins_valid, ins, ins_tid, 16'(i), exp_v[i], exp_ins[i]);
      end
      cyc();
    end
  endtask

  task automatic test_round_robin;
    logic [15:0] exp_addr [6];
    logic [1:0]  exp_tid  [6];
    exp_addr[0] = 16'h0; exp_addr[1] = 16'h0; exp_addr[2] = 16'h0;
    exp_addr[3] = 16'h0; exp_addr[4] = 16'h1; exp_addr[5] = 16'h1;
    exp_tid[0] = 2'd0; exp_tid[1] = 2'd1; exp_tid[2] = 2'd2;
    exp_tid[3] = 2'd3; exp_tid[4] = 2'd0; exp_tid[5] = 2'd1;
    do_reset();
    core_en = 4'b1111;
    for (int i = 0; i < 7; i++) begin
      #1;
      if (i < 6) begin
        checks++;
        if (fetch_addr !== exp_addr[i]) begin
          errors++;
          $display("FAIL rr_addr%0d: got %h want %h", i, fetch_addr, exp_addr[i]);
        end
      end else begin
        checks = checks;
      end
      if (i > 0) begin
        checks++;
        if (ins_valid !== 1'b1 || ins_tid !== exp_tid[i-1] || ins !== (exp_addr[i-1] ^ 16'hA5A5)) begin
          errors++;
          $display("FAIL rr_ins%0d: got valid=%b tid=%0d ins=%h, want 1/%0d/%h",
                   i, ins_valid, ins_tid, ins, exp_tid[i-1], exp_addr[i-1] ^ 16'hA5A5);
        end
      end else begin
        checks = checks;
      end
      cyc();
    end
  endtask

  task automatic test_branch_squash;
    do_reset();
    core_en = 4'b0001;
    repeat (5) cyc();
    branch_en = 1'b1; branch_tid = 2'd0; branch_val = 16'h1234;
    #1;
    checks++;
    if (fetch_addr !== 16'h1234 || ins_valid !== 1'b0 || ins !== 16'h0000) begin
      errors++;
      $display("FAIL branch_squash: got addr=%h valid=%b ins=%h, want 1234/0/0000",
               fetch_addr, ins_valid, ins);
    end
    cyc();
    branch_en = 1'b0;
    #1;
    checks++;
    if (fetch_addr !== 16'h1235 || ins_valid !== 1'b1 || ins !== 16'hB791 || ins_tid !== 2'd0) begin
      errors++;
      $display("FAIL branch_follow: got addr=%h valid=%b ins=%h tid=%0d, want 1235/1/B791/0",
               fetch_addr, ins_valid, ins, ins_tid);
    end
    cyc();
  endtask

  task automatic test_stall;
    do_reset();
    core_en = 4'b0001;
    repeat (8) cyc();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (fetch_addr !== 16'h0007 || ins_valid !== 1'b0 || ins !== 16'h0000) begin
        errors++;
        $display("FAIL stall_hold%0d: got addr=%h valid=%b ins=%h, want 0007/0/0000",
                 i, fetch_addr, ins_valid, ins);
      end
      cyc();
    end
    stall = 1'b0;
    #1;
    checks++;
    if (fetch_addr !== 16'h0008 || ins_valid !== 1'b1 || ins !== 16'hA5A2) begin
      errors++;
      $display("FAIL stall_release: got addr=%h valid=%b ins=%h, want 0008/1/A5A2",
               fetch_addr, ins_valid, ins);
    end
    cyc();
    #1;
    checks++;
    if (fetch_addr !== 16'h0009 || ins_valid !== 1'b1 || ins !== 16'hA5AD) begin
      errors++;
      $display("FAIL stall_once: got addr=%h valid=%b ins=%h, want 0009/1/A5AD",
               fetch_addr, ins_valid, ins);
    end
    cyc();
  endtask

  task automatic test_wrap;
    do_reset();
    core_en = 4'b0100;
    branch_en = 1'b1; branch_tid = 2'd2; branch_val = 16'hFFFF;
    #1;
    checks++;
    if (fetch_addr !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_branch: got addr=%h want FFFF", fetch_addr);
    end
    cyc();
    branch_en = 1'b0;
    #1;
    checks++;
    if (fetch_addr !== 16'h0000 || ins_valid !== 1'b1 || ins !== 16'h5A5A || ins_tid !== 2'd2) begin
      errors++;
      $display("FAIL wrap_zero: got addr=%h valid=%b ins=%h tid=%0d, want 0000/1/5A5A/2",
               fetch_addr, ins_valid, ins, ins_tid);
    end
    cyc();
  endtask

  task automatic test_branch_other;
    do_reset();
    core_en = 4'b0001;
    branch_en = 1'b1; branch_tid = 2'd1; branch_val = 16'h0100;
    #1;
    checks++;
    if (fetch_addr !== 16'h0000) begin
      errors++;
      $display("FAIL other_sel: got addr=%h want 0000", fetch_addr);
    end
    cyc();
    branch_en = 1'b0;
    core_en = 4'b0010;
    #1;
    checks++;
    if (fetch_addr !== 16'h0100 || ins_valid !== 1'b0) begin
      errors++;
      $display("FAIL other_resume: got addr=%h valid=%b, want 0100/0", fetch_addr, ins_valid);
    end
    cyc();
    #1;
    checks++;
    if (ins_valid !== 1'b1 || ins_tid !== 2'd1 || ins !== 16'hA4A5) begin
      errors++;
      $display("FAIL other_ins: got valid=%b tid=%0d ins=%h, want 1/1/A4A5", ins_valid, ins_tid, ins);
    end
    cyc();
  endtask

  task automatic test_async_reset;
    do_reset();
    core_en = 4'b1111;
    repeat (5) cyc();
    #1;
    checks++;
    if (fetch_addr !== 16'h0001 || ins_valid !== 1'b1 || ins_tid !== 2'd0) begin
      errors++;
      $display("FAIL arst_pre: got addr=%h valid=%b tid=%0d, want 0001/1/0", fetch_addr, ins_valid, ins_tid);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (fetch_addr !== 16'h0000 || ins_valid !== 1'b0 || ins !== 16'h0000) begin
      errors++;
      $display("FAIL arst_mid: got addr=%h valid=%b ins=%h, want 0000/0/0000", fetch_addr, ins_valid, ins);
    end
    cyc();
    rst = 1'b0;
    #1;
    checks++;
    if (fetch_addr !== 16'h0000) begin
      errors++;
      $display("FAIL arst_first: got addr=%h want 0000", fetch_addr);
    end
    cyc();
    #1;
    checks++;
    if (ins_valid !== 1'b1 || ins_tid !== 2'd0 || ins !== 16'hA5A5) begin
      errors++;
      $display("FAIL arst_order: got valid=%b tid=%0d ins=%h, want 1/0/A5A5", ins_valid, ins_tid, ins);
    end
    cyc();
  endtask

  initial begin
    test_reset();
    test_single_thread();
    test_round_robin();
    test_branch_squash();
    test_stall();
    test_wrap();
    test_branch_other();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
